axi_rd_mux: RTL and testbench
=============================

AXI_RD_MUX -- requirements
Module: axi_rd_mux

Interface
REQ-001 SHALL have parameter REQ_WIDTH, default 2, number of upstream masters.
REQ-002 SHALL have parameter ADDR_W, default 32, AR address width.
REQ-003 SHALL have parameter DATA_W, default 32, R data width.
REQ-004 SHALL have parameter LEN_W, default 4, burst length field width (beats = len+1).
REQ-005 SHALL have port clk, input, 1, single clock; all logic on posedge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port req, output, REQ_WIDTH, request vector to arbiter; equal to m_arvalid.
REQ-008 SHALL have port grant, input, REQ_WIDTH, one-hot grant from arbiter.
REQ-009 SHALL have port lock, output, 1, freezes arbiter pointer while a transaction is in flight.
REQ-010 SHALL have ports m_arvalid (input, REQ_WIDTH), m_araddr (input, REQ_WIDTH x ADDR_W), m_arlen (input, REQ_WIDTH x LEN_W) and m_arready (output, REQ_WIDTH) as the per-master AR channel.
REQ-011 SHALL have ports m_rvalid (output, REQ_WIDTH), m_rready (input, REQ_WIDTH), m_rdata (output, DATA_W, shared) and m_rlast (output, 1, shared) as the per-master R channel.
REQ-012 SHALL have ports s_arvalid (output, 1), s_araddr (output, ADDR_W), s_arlen (output, LEN_W) and s_arready (input, 1) as the slave AR channel.
REQ-013 SHALL have ports s_rvalid (input, 1), s_rdata (input, DATA_W), s_rlast (input, 1) and s_rready (output, 1) as the slave R channel.
REQ-014 SHALL have port rd_err, output, 1, sticky protocol-error flag.

Function
REQ-015 SHALL implement a three-state FSM with states IDLE, ADDR and DATA.
REQ-016 SHALL drive lock=1 whenever state!=IDLE.
REQ-017 SHALL, in IDLE with |grant=1, register sel=index of grant (lowest set bit if multi-hot) and enter ADDR on the next cycle; grant=0 stays IDLE.
REQ-018 SHALL, in ADDR, drive s_arvalid=m_arvalid[sel], s_araddr=m_araddr[sel], s_arlen=m_arlen[sel], m_arready[sel]=s_arready, and all other m_arready bits 0.
REQ-019 SHALL, on AR handshake (s_arvalid & s_arready), load beat counter=s_arlen and enter DATA; if m_arvalid[sel] drops in ADDR, stay in ADDR with s_arvalid=0.
REQ-020 SHALL, in DATA, drive m_rvalid[sel]=s_rvalid, s_rready=m_rready[sel], m_rdata=s_rdata, m_rlast=s_rlast; other m_rvalid bits 0.
REQ-021 SHALL, on each R handshake, decrement the counter (non-wrapping) and return to IDLE on the handshake carrying s_rlast=1.
REQ-022 SHALL set rd_err if s_rlast=1 while counter!=0 (early last; still returns to IDLE).
REQ-023 SHALL set rd_err if a handshake occurs with counter=0 and s_rlast=0 (missing last; remains in DATA until s_rlast).
REQ-024 SHALL set rd_err if s_rvalid=1 while in IDLE or ADDR; s_rready SHALL be 0 outside DATA.
REQ-025 SHALL drive s_arvalid=0 and m_arready=0 outside ADDR.
REQ-026 SHALL present the AR to the slave one cycle after grant is sampled, with zero added latency on R (combinational routing).
REQ-027 SHALL ignore grant changes while lock=1.

Reset
REQ-028 SHALL, on rst=1 (including mid-burst), enter IDLE and clear sel, counter and rd_err on the next edge.
REQ-029 SHALL hold lock, s_arvalid, s_rready, m_arready, m_rvalid and rd_err at 0 during reset.
REQ-030 SHALL release rd_err only via rst.

Structure
REQ-031 SHALL place the FSM state enum and default width constants in shared package axi_pkg.
REQ-032 SHALL be a single flat module with no sub-modules; the arbiter is instantiated alongside it at the interconnect top.

Verification
REQ-033 SHALL cover single read: master0 AR addr=0x100, len=3, grant=01 -> s_arvalid next cycle, 4 R beats routed to master0, lock high from grant+1 to last beat, then IDLE.
REQ-034 SHALL cover contention: both arvalid, grant=10 -> master1 served fully, master0 m_arready=0 and m_rvalid=0 throughout.
REQ-035 SHALL cover backpressure: s_arready low 3 cycles, m_rready toggling -> no beat lost or duplicated, counter reaches 0 exactly on rlast.
REQ-036 SHALL cover early last: len=3, s_rlast on beat 2 -> rd_err=1 and IDLE; rd_err still 1 after next transaction.
REQ-037 SHALL cover reset mid-DATA: rst after beat 1 -> next cycle IDLE, lock=0, rd_err=0, all valids/readies 0.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared types and default widths for the AXI read-channel mux.
package axi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam int DEF_REQ_WIDTH = 2;
    localparam int DEF_ADDR_W    = 32;
    localparam int DEF_DATA_W    = 32;
    localparam int DEF_LEN_W     = 4;

endpackage

// File: rtl/axi_rd_mux.sv
// Routes one granted master's AR request and its R burst to a single slave,
// holding the arbiter locked until the burst ends, with a sticky error flag.
module axi_rd_mux
    import axi_pkg::*;
#(
    parameter int REQ_WIDTH = DEF_REQ_WIDTH,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int LEN_W     = DEF_LEN_W
) (
    input  logic                             clk,
    input  logic                             rst,
    output logic [REQ_WIDTH-1:0]             req,
    input  logic [REQ_WIDTH-1:0]             grant,
    output logic                             lock,
    input  logic [REQ_WIDTH-1:0]             m_arvalid,
    input  logic [REQ_WIDTH-1:0][ADDR_W-1:0] m_araddr,
    input  logic [REQ_WIDTH-1:0][LEN_W-1:0]  m_arlen,
    output logic [REQ_WIDTH-1:0]             m_arready,
    output logic [REQ_WIDTH-1:0]             m_rvalid,
    input  logic [REQ_WIDTH-1:0]             m_rready,
    output logic [DATA_W-1:0]                m_rdata,
    output logic                             m_rlast,
    output logic                             s_arvalid,
    output logic [ADDR_W-1:0]                s_araddr,
    output logic [LEN_W-1:0]                 s_arlen,
    input  logic                             s_arready,
    input  logic                             s_rvalid,
    input  logic [DATA_W-1:0]                s_rdata,
    input  logic                             s_rlast,
    output logic                             s_rready,
    output logic                             rd_err
);

    localparam int SEL_W = (REQ_WIDTH > 1) ? $clog2(REQ_WIDTH) : 1;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic [SEL_W-1:0]   gidx;
    logic               r_hs;

    assign req    = m_arvalid;
    assign lock   = (state_q != IDLE) && !rst;
    assign rd_err = err_q;

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        s_arvalid = 1'b0;
        s_araddr  = '0;
        s_arlen   = '0;
        m_arready = '0;
        m_rvalid  = '0;
        s_rready  = 1'b0;
        m_rdata   = '0;
        m_rlast   = 1'b0;
        r_hs      = 1'b0;

        // Descending scan so the lowest set grant bit wins.
        gidx = '0;
        for (int i = REQ_WIDTH - 1; i >= 0; i--) begin
            if (grant[i]) gidx = SEL_W'(i);
        end

        case (state_q)
            IDLE: begin
                if (s_rvalid) err_d = 1'b1;
                if (|grant) begin
                    sel_d   = gidx;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (s_rvalid) err_d = 1'b1;
                s_arvalid        = m_arvalid[sel_q];
                s_araddr         = m_araddr[sel_q];
                s_arlen          = m_arlen[sel_q];
                m_arready[sel_q] = s_arready;
                if (s_arvalid && s_arready) begin
                    cnt_d   = s_arlen;
                    state_d = DATA;
                end
            end
            DATA: begin
                m_rvalid[sel_q] = s_rvalid;
                s_rready        = m_rready[sel_q];
                m_rdata         = s_rdata;
                m_rlast         = s_rlast;
                r_hs            = s_rvalid && s_rready;
                if (r_hs) begin
                    if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
                    // Early last and missing last both flag; only rlast ends the burst.
                    if (s_rlast) begin
                        if (cnt_q != '0) err_d = 1'b1;
                        state_d = IDLE;
                    end else if (cnt_q == '0) begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (rst) begin
            s_arvalid = 1'b0;
            m_arready = '0;
            m_rvalid  = '0;
            s_rready  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_axi_rd_mux.sv
// Directed bench for axi_rd_mux: inputs change on negedge, outputs checked #1 later.
module tb_axi_rd_mux;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       req, grant, m_arvalid, m_arready, m_rvalid, m_rready;
    logic [1:0][31:0] m_araddr;
    logic [1:0][3:0]  m_arlen;
    logic [31:0]      m_rdata, s_araddr, s_rdata;
    logic             m_rlast, lock, s_arvalid, s_arready, s_rvalid, s_rlast, s_rready, rd_err;
    logic [3:0]       s_arlen;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    axi_rd_mux dut (
        .clk(clk), .rst(rst), .req(req), .grant(grant), .lock(lock),
        .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arready(m_arready),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rlast(m_rlast),
        .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arready(s_arready),
        .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rlast(s_rlast), .s_rready(s_rready),
        .rd_err(rd_err)
    );

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        grant = '0; m_arvalid = '0; m_araddr = '0; m_arlen = '0; m_rready = '0;
        s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = '0; s_rlast = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        s_rvalid = 1'b1;
        m_rready = 2'b11;
        cyc(); cyc();
        #1;
        n_chk++;
        if ({lock, s_arvalid, s_rready, m_arready, m_rvalid, rd_err} !== 8'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: lock=%b s_arvalid=%b s_rready=%b m_arready=%b m_rvalid=%b rd_err=%b, required all 0",
                     lock, s_arvalid, s_rready, m_arready, m_rvalid, rd_err);
        end
        clear_inputs();
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_single();
        m_arvalid = 2'b01; m_araddr[0] = 32'h100; m_arlen[0] = 4'd3; grant = 2'b01;
        #1;
        n_chk++;
        if (req !== 2'b01 || lock !== 1'b0 || s_arvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_idle: req=%b lock=%b s_arvalid=%b, required 01 0 0", req, lock, s_arvalid);
        end
        cyc();
        grant = '0;
        #1;
        n_chk++;
        if (lock !== 1'b1 || s_arvalid !== 1'b1 || s_araddr !== 32'h100 || s_arlen !== 4'd3 || m_arready !== 2'b00) begin
            n_fail++;
            $display("FAIL single_addr: lock=%b s_arvalid=%b s_araddr=%h s_arlen=%0d m_arready=%b, required 1 1 100 3 00",
                     lock, s_arvalid, s_araddr, s_arlen, m_arready);
        end
        s_arready = 1'b1;
        #1;
        n_chk++;
        if (m_arready !== 2'b01) begin
            n_fail++;
            $display("FAIL single_arready: m_arready=%b, required 01", m_arready);
        end
        cyc();
        m_arvalid = '0; s_arready = 1'b0;
        for (int b = 0; b < 4; b++) begin
            s_rvalid = 1'b1; s_rdata = 32'hA0 + b; s_rlast = (b == 3); m_rready = 2'b01;
            grant = 2'b10;
            #1;
            n_chk++;
            if (m_rvalid !== 2'b01 || m_rdata !== 32'hA0 + b || m_rlast !== (b == 3) || s_rready !== 1'b1 || lock !== 1'b1) begin
                n_fail++;
                $display("FAIL single_beat%0d: m_rvalid=%b m_rdata=%h m_rlast=%b s_rready=%b lock=%b, required 01 %h %b 1 1",
                         b, m_rvalid, m_rdata, m_rlast, s_rready, lock, 32'hA0 + b, (b == 3));
            end
            cyc();
        end
        clear_inputs();
        #1;
        n_chk++;
        if (lock !== 1'b0 || rd_err !== 1'b0 || s_rready !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done: lock=%b rd_err=%b s_rready=%b, required 0 0 0", lock, rd_err, s_rready);
        end
    endtask

    task automatic test_contention();
        m_arvalid = 2'b11; m_araddr[0] = 32'h111; m_araddr[1] = 32'h200; m_arlen[0] = 4'd5; m_arlen[1] = 4'd1;
        grant = 2'b10;
        cyc();
        grant = '0; s_arready = 1'b1;
        #1;
        n_chk++;
        if (s_araddr !== 32'h200 || s_arlen !== 4'd1 || m_arready !== 2'b10) begin
            n_fail++;
            $display("FAIL contention_addr: s_araddr=%h s_arlen=%0d m_arready=%b, required 200 1 10", s_araddr, s_arlen, m_arready);
        end
        cyc();
        m_arvalid = 2'b01; s_arready = 1'b1;
        for (int b = 0; b < 2; b++) begin
            s_rvalid = 1'b1; s_rdata = 32'hC0 + b; s_rlast = (b == 1); m_rready = 2'b11;
            #1;
            n_chk++;
            if (m_rvalid !== 2'b10 || m_arready !== 2'b00 || s_arvalid !== 1'b0) begin
                n_fail++;
                $display("FAIL contention_beat%0d: m_rvalid=%b m_arready=%b s_arvalid=%b, required 10 00 0",
                         b, m_rvalid, m_arready, s_arvalid);
            end
            cyc();
        end
        clear_inputs();
        #1;
        n_chk++;
        if (lock !== 1'b0 || rd_err !== 1'b0) begin
            n_fail++;
            $display("FAIL contention_done: lock=%b rd_err=%b, required 0 0", lock, rd_err);
        end
    endtask

    task automatic test_backpressure();
        int beat = 0;
        int c;
        m_arvalid = 2'b01; m_araddr[0] = 32'h300; m_arlen[0] = 4'd2; grant = 2'b01;
        cyc();
        grant = '0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_chk++;
            if (s_arvalid !== 1'b1 || m_arready !== 2'b00 || lock !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_arstall%0d: s_arvalid=%b m_arready=%b lock=%b, required 1 00 1", i, s_arvalid, m_arready, lock);
            end
            cyc();
        end
        s_arready = 1'b1;
        cyc();
        m_arvalid = '0; s_arready = 1'b0;
        for (c = 0; c < 12 && beat < 3; c++) begin
            s_rvalid = 1'b1; s_rdata = 32'hB0 + beat; s_rlast = (beat == 2); m_rready = {1'b0, c[0]};
            #1;
            n_chk++;
            if (m_rdata !== 32'hB0 + beat || s_rready !== c[0] || lock !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_cycle%0d: m_rdata=%h s_rready=%b lock=%b, required %h %b 1",
                         c, m_rdata, s_rready, lock, 32'hB0 + beat, c[0]);
            end
            if (c[0]) beat++;
            cyc();
        end
        clear_inputs();
        #1;
        n_chk++;
        if (beat != 3 || lock !== 1'b0 || rd_err !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_done: beats=%0d lock=%b rd_err=%b, required 3 0 0", beat, lock, rd_err);
        end
    endtask

    task automatic test_early_last();
        m_arvalid = 2'b01; m_araddr[0] = 32'h400; m_arlen[0] = 4'd3; grant = 2'b01;
        cyc();
        grant = '0; s_arready = 1'b1;
        cyc();
        m_arvalid = '0; s_arready = 1'b0;
        for (int b = 0; b < 3; b++) begin
            s_rvalid = 1'b1; s_rdata = 32'hE0 + b; s_rlast = (b == 2); m_rready = 2'b01;
            cyc();
        end
        clear_inputs();
        #1;
        n_chk++;
        if (rd_err !== 1'b1 || lock !== 1'b0) begin
            n_fail++;
            $display("FAIL early_last: rd_err=%b lock=%b, required 1 0", rd_err, lock);
        end
        m_arvalid = 2'b10; m_araddr[1] = 32'h500; m_arlen[1] = 4'd0; grant = 2'b10;
        cyc();
        grant = '0; s_arready = 1'b1;
        cyc();
        m_arvalid = '0; s_arready = 1'b0;
        s_rvalid = 1'b1; s_rlast = 1'b1; m_rready = 2'b10;
        cyc();
        clear_inputs();
        #1;
        n_chk++;
        if (rd_err !== 1'b1 || lock !== 1'b0) begin
            n_fail++;
            $display("FAIL early_last_sticky: rd_err=%b lock=%b, required 1 0", rd_err, lock);
        end
    endtask

    task automatic test_reset_mid();
        m_arvalid = 2'b01; m_araddr[0] = 32'h600; m_arlen[0] = 4'd3; grant = 2'b01;
        cyc();
        grant = '0; s_arready = 1'b1;
        cyc();
        m_arvalid = '0; s_arready = 1'b0;
        s_rvalid = 1'b1; s_rdata = 32'h61; m_rready = 2'b01;
        cyc();
        rst = 1'b1;
        #1;
        n_chk++;
        if (lock !== 1'b0 || m_rvalid !== 2'b00 || s_rready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_during: lock=%b m_rvalid=%b s_rready=%b, required 0 00 0", lock, m_rvalid, s_rready);
        end
        cyc();
        rst = 1'b0;
        #1;
        n_chk++;
        if ({lock, rd_err, s_arvalid, s_rready, m_arready, m_rvalid} !== 8'b0) begin
            n_fail++;
            $display("FAIL rst_mid_after: lock=%b rd_err=%b s_arvalid=%b s_rready=%b m_arready=%b m_rvalid=%b, required all 0",
                     lock, rd_err, s_arvalid, s_rready, m_arready, m_rvalid);
        end
        cyc();
        s_rvalid = 1'b0;
        #1;
        n_chk++;
        if (rd_err !== 1'b1 || lock !== 1'b0) begin
            n_fail++;
            $display("FAIL stray_rvalid: rd_err=%b lock=%b, required 1 0", rd_err, lock);
        end
        clear_inputs();
    endtask

    task automatic test_missing_last();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        m_arvalid = 2'b10; m_araddr[1] = 32'h700; m_arlen[1] = 4'd0; grant = 2'b10;
        cyc();
        grant = '0;
        m_arvalid = 2'b00;
        s_arready = 1'b1;
        #1;
        n_chk++;
        if (s_arvalid !== 1'b0 || lock !== 1'b1 || rd_err !== 1'b0) begin
            n_fail++;
            $display("FAIL arvalid_drop: s_arvalid=%b lock=%b rd_err=%b, required 0 1 0", s_arvalid, lock, rd_err);
        end
        cyc();
        m_arvalid = 2'b10;
        cyc();
        m_arvalid = '0; s_arready = 1'b0;
        s_rvalid = 1'b1; s_rlast = 1'b0; m_rready = 2'b10;
        cyc();
        #1;
        n_chk++;
        if (rd_err !== 1'b1 || lock !== 1'b1 || m_rvalid !== 2'b10) begin
            n_fail++;
            $display("FAIL missing_last: rd_err=%b lock=%b m_rvalid=%b, required 1 1 10", rd_err, lock, m_rvalid);
        end
        s_rlast = 1'b1;
        cyc();
        clear_inputs();
        #1;
        n_chk++;
        if (lock !== 1'b0 || rd_err !== 1'b1) begin
            n_fail++;
            $display("FAIL missing_last_done: lock=%b rd_err=%b, required 0 1", lock, rd_err);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_early_last();
        test_reset_mid();
        test_missing_last();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
